// File: rtl/assist_motor_sequencer.sv
// ---------------------------------------------------------------------------
// assist_motor_sequencer
//   Turns the assistance calculator's requested assistance into a
//   slew-limited, saturated motor command. The command is gated by pedalling
//   (cadence activity), the brake lever and a latched tilt fault.
//
// Ports
//   clk                    system clock (single domain)
//   reset                  asynchronous active-high reset
//   AssistanceRequirement  [12:0] unsigned requested assistance
//   ResolvedRoll           [9:0]  signed roll angle, degrees
//   cadence                raw pedal-sensor pulse (asynchronous)
//   brake                  raw brake lever, active-high (asynchronous)
//   MotorCommand           [12:0] command to current control
//   MotorEnable            high only in RUN
//   TiltFault              high in TILT
//   Pedalling              cadence-alive flag
//   State                  [1:0] IDLE=0, RUN=1, BRAKE=2, TILT=3
//   All outputs come straight from flops.
// ---------------------------------------------------------------------------
module assist_motor_sequencer #(
    parameter int TICK_DIV        = 50000,
    parameter int RAMP_UP_STEP    = 8,
    parameter int RAMP_DOWN_STEP  = 64,
    parameter int MAX_CMD         = 4000,
    parameter int CADENCE_TIMEOUT = 1500,
    parameter int ROLL_LIMIT      = 45,
    parameter int ROLL_HYST       = 5,
    parameter int RECOVER_TICKS   = 500
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [12:0] AssistanceRequirement,
    input  logic [9:0]  ResolvedRoll,
    input  logic        cadence,
    input  logic        brake,
    output logic [12:0] MotorCommand,
    output logic        MotorEnable,
    output logic        TiltFault,
    output logic        Pedalling,
    output logic [1:0]  State
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = $clog2(CADENCE_TIMEOUT + 1);
    localparam int RW = $clog2(RECOVER_TICKS + 1);

    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CAD_MAX   = CW'(CADENCE_TIMEOUT);
    localparam logic [RW-1:0] REC_DONE  = RW'(RECOVER_TICKS);
    localparam logic [12:0]   CMD_MAX   = 13'(MAX_CMD);
    localparam logic [12:0]   UP_STEP   = 13'(RAMP_UP_STEP);
    localparam logic [12:0]   DN_STEP   = 13'(RAMP_DOWN_STEP);
    localparam logic [10:0]   TILT_LIM  = 11'(ROLL_LIMIT);
    localparam logic [10:0]   UPR_LIM   = 11'(ROLL_LIMIT - ROLL_HYST);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_BRAKE = 2'd2,
        S_TILT  = 2'd3
    } state_t;

    // ---------------- registers ----------------
    logic [2:0]    cad_sync_q, cad_sync_d;   // [2] is the edge-detect history flop
    logic [1:0]    brk_sync_q, brk_sync_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [CW-1:0] cad_cnt_q, cad_cnt_d;
    logic          ped_q, ped_d;
    state_t        state_q, state_d;
    logic [12:0]   cmd_q, cmd_d;
    logic [RW-1:0] rec_q, rec_d;
    logic          en_q, en_d;
    logic          tf_q, tf_d;

    // ---------------- combinational helpers ----------------
    logic        tick;
    logic        cad_edge;
    logic        brk_s;
    logic [10:0] roll_ext;
    logic [10:0] abs_roll;
    logic        tilt;
    logic        upright;
    logic [12:0] ar_clamp;
    logic [12:0] tgt;
    logic [12:0] gap_up;
    logic [12:0] gap_dn;
    logic [RW-1:0] rec_inc;

    assign tick     = (presc_q == PRESC_MAX);
    assign cad_edge = cad_sync_q[1] & ~cad_sync_q[2];
    assign brk_s    = brk_sync_q[1];

    // Sign-extend to 11 bits so that -512 has a representable magnitude.
    assign roll_ext = {ResolvedRoll[9], ResolvedRoll};
    assign abs_roll = roll_ext[10] ? (~roll_ext + 11'd1) : roll_ext;
    assign tilt     = (abs_roll > TILT_LIM);
    assign upright  = (abs_roll <= UPR_LIM);

    assign ar_clamp = (AssistanceRequirement > CMD_MAX) ? CMD_MAX : AssistanceRequirement;
    assign tgt      = ped_q ? ar_clamp : 13'd0;
    assign gap_up   = tgt - cmd_q;     // only used when tgt > cmd
    assign gap_dn   = cmd_q - tgt;     // only used when cmd > tgt
    assign rec_inc  = rec_q + RW'(1);

    // ---------------- synchronisers, tick, cadence watchdog ----------------
    always_comb begin
        cad_sync_d = {cad_sync_q[1:0], cadence};
        brk_sync_d = {brk_sync_q[0], brake};
        presc_d    = tick ? '0 : presc_q + PW'(1);

        cad_cnt_d = cad_cnt_q;
        if (cad_edge)                          // edge beats a coincident tick
            cad_cnt_d = '0;
        else if (tick && (cad_cnt_q < CAD_MAX))
            cad_cnt_d = cad_cnt_q + CW'(1);

        ped_d = (cad_cnt_d < CAD_MAX);
    end

    // ---------------- sequencer FSM ----------------
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        rec_d   = rec_q;

        if (tilt) begin
            state_d = S_TILT;
            cmd_d   = '0;
            rec_d   = '0;
        end else if ((state_q != S_TILT) && brk_s) begin
            state_d = S_BRAKE;
            cmd_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cmd_d = '0;
                    if (ped_q)
                        state_d = S_RUN;
                end
                S_RUN: begin
                    if (tick) begin
                        if (cmd_q < tgt)
                            cmd_d = cmd_q + ((gap_up > UP_STEP) ? UP_STEP : gap_up);
                        else if (cmd_q > tgt)
                            cmd_d = cmd_q - ((gap_dn > DN_STEP) ? DN_STEP : gap_dn);
                    end
                    if (!ped_q && (cmd_q == 13'd0))
                        state_d = S_IDLE;
                end
                S_BRAKE: begin
                    // Brake already released here; ramp restarts from zero via IDLE.
                    cmd_d   = '0;
                    state_d = S_IDLE;
                end
                S_TILT: begin
                    cmd_d = '0;
                    if (!upright) begin
                        rec_d = '0;
                    end else if (tick) begin
                        rec_d = rec_inc;
                        if (rec_inc == REC_DONE) begin
                            rec_d   = '0;
                            state_d = S_IDLE;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        en_d = (state_d == S_RUN);
        tf_d = (state_d == S_TILT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cad_sync_q <= '0;
            brk_sync_q <= '0;
            presc_q    <= '0;
            cad_cnt_q  <= CAD_MAX;
            ped_q      <= 1'b0;
            state_q    <= S_IDLE;
            cmd_q      <= '0;
            rec_q      <= '0;
            en_q       <= 1'b0;
            tf_q       <= 1'b0;
        end else begin
            cad_sync_q <= cad_sync_d;
            brk_sync_q <= brk_sync_d;
            presc_q    <= presc_d;
            cad_cnt_q  <= cad_cnt_d;
            ped_q      <= ped_d;
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            rec_q      <= rec_d;
            en_q       <= en_d;
            tf_q       <= tf_d;
        end
    end

    assign MotorCommand = cmd_q;
    assign MotorEnable  = en_q;
    assign TiltFault    = tf_q;
    assign Pedalling    = ped_q;
    assign State        = state_q;

endmodule

// File: tb/tb_assist_motor_sequencer.sv
module tb_assist_motor_sequencer;

    localparam int TD   = 4;
    localparam int RU   = 8;
    localparam int RD   = 64;
    localparam int MAXC = 4000;
    localparam int CT   = 10;
    localparam int RL   = 45;
    localparam int RH   = 5;
    localparam int RT   = 5;

    localparam int IDLE = 0, RUN = 1, BRK = 2, TILT = 3;

    logic        clk;
    logic        reset;
    logic [12:0] AssistanceRequirement;
    logic [9:0]  ResolvedRoll;
    logic        cadence;
    logic        brake;
    logic [12:0] MotorCommand;
    logic        MotorEnable;
    logic        TiltFault;
    logic        Pedalling;
    logic [1:0]  State;

    assist_motor_sequencer #(
        .TICK_DIV(TD), .RAMP_UP_STEP(RU), .RAMP_DOWN_STEP(RD), .MAX_CMD(MAXC),
        .CADENCE_TIMEOUT(CT), .ROLL_LIMIT(RL), .ROLL_HYST(RH), .RECOVER_TICKS(RT)
    ) dut (
        .clk(clk), .reset(reset),
        .AssistanceRequirement(AssistanceRequirement), .ResolvedRoll(ResolvedRoll),
        .cadence(cadence), .brake(brake),
        .MotorCommand(MotorCommand), .MotorEnable(MotorEnable),
        .TiltFault(TiltFault), .Pedalling(Pedalling), .State(State)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // stimulus sources
    int ar_i, roll_i, brk_i, rst_i, cad_i, cad_period, cad_force, cyc;
    // reference model: input delay lines, tick phase, watchdog, mode, command
    int m_cad[3];
    int m_brk[2];
    int m_phase, m_quiet, m_ped, m_st, m_cmd, m_rec;
    int max_seen;
    int n_cmp, n_err;

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cad = '{0, 0, 0};
        m_brk = '{0, 0};
        m_phase = 0; m_quiet = CT; m_ped = 0;
        m_st = IDLE; m_cmd = 0; m_rec = 0;
    endtask

    // One clock edge of the reference behaviour, written from the rules:
    // ticks every TD cycles, cadence watchdog in ticks, priority tilt > brake > run.
    task automatic model_edge();
        int tick_now, rose, brk_seen, quiet, mag, goal, st, cmd, rec;
        tick_now = (m_phase == TD - 1);
        rose     = (m_cad[1] == 1) && (m_cad[2] == 0);
        brk_seen = m_brk[1];
        mag      = (roll_i < 0) ? -roll_i : roll_i;
        goal     = m_ped ? imin(ar_i, MAXC) : 0;
        quiet    = rose ? 0 : (tick_now ? imin(m_quiet + 1, CT) : m_quiet);
        st = m_st; cmd = m_cmd; rec = m_rec;
        if (mag > RL) begin
            st = TILT; cmd = 0; rec = 0;
        end else if (m_st != TILT && brk_seen != 0) begin
            st = BRK; cmd = 0;
        end else if (m_st == IDLE) begin
            cmd = 0;
            if (m_ped != 0) st = RUN;
        end else if (m_st == RUN) begin
            if (tick_now) cmd = (m_cmd < goal) ? m_cmd + imin(RU, goal - m_cmd)
                                               : m_cmd - imin(RD, m_cmd - goal);
            if (m_ped == 0 && m_cmd == 0) st = IDLE;
        end else if (m_st == BRK) begin
            cmd = 0; st = IDLE;
        end else begin
            cmd = 0;
            if (mag > RL - RH) rec = 0;
            else if (tick_now) begin
                rec = m_rec + 1;
                if (rec == RT) begin rec = 0; st = IDLE; end
            end
        end
        m_cad[2] = m_cad[1]; m_cad[1] = m_cad[0]; m_cad[0] = cad_i;
        m_brk[1] = m_brk[0]; m_brk[0] = brk_i;
        m_phase = (m_phase + 1) % TD;
        m_quiet = quiet;
        m_ped   = (quiet < CT);
        m_st = st; m_cmd = cmd; m_rec = rec;
    endtask

    task automatic check_all();
        chk("cmd",  32'(MotorCommand), 32'(m_cmd));
        chk("state", 32'(State), 32'(m_st));
        chk("enable", 32'(MotorEnable), 32'(m_st == RUN));
        chk("tiltfault", 32'(TiltFault), 32'(m_st == TILT));
        chk("pedalling", 32'(Pedalling), 32'(m_ped));
        if (int'(MotorCommand) > max_seen) max_seen = int'(MotorCommand);
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        cad_i = (cad_period > 0) ? int'((cyc % cad_period) < 2) : cad_force;
        reset                 = rst_i[0];
        AssistanceRequirement = 13'(ar_i);
        ResolvedRoll          = 10'(roll_i);
        cadence               = cad_i[0];
        brake                 = brk_i[0];
        @(posedge clk);
        if (rst_i != 0) model_reset(); else model_edge();
        #1 check_all();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_cmd(input string tag, input int target, input int budget);
        for (int i = 0; i < budget && m_cmd != target; i++) step();
        chk(tag, 32'(MotorCommand), 32'(target));
    endtask

    initial begin
        n_cmp = 0; n_err = 0; cyc = 0; max_seen = 0;
        ar_i = 0; roll_i = 0; brk_i = 0; rst_i = 1; cad_period = 0; cad_force = 0; cad_i = 0;
        reset = 1'b1; AssistanceRequirement = '0; ResolvedRoll = '0; cadence = 1'b0; brake = 1'b0;
        model_reset();
        #1;
        chk("rst_cmd", 32'(MotorCommand), 0);
        chk("rst_state", 32'(State), IDLE);
        chk("rst_ped", 32'(Pedalling), 0);
        steps(2);
        rst_i = 0;

        // 1. ramp-up to 100 with cadence every 3 ticks
        cad_period = 3 * TD; ar_i = 100;
        steps(30 * TD);
        chk("ramp_hold", 32'(MotorCommand), 100);
        chk("ramp_state", 32'(State), RUN);

        // 2. saturation, then ramp-down to zero
        ar_i = 8191; max_seen = 0;
        wait_cmd("sat_reach", 4000, 2500);
        steps(3 * TD);
        chk("sat_max", 32'(max_seen), 4000);
        ar_i = 0;
        for (int i = 0; i < 2 * TD && m_cmd == 4000; i++) step();
        chk("down_first", 32'(MotorCommand), 3936);
        wait_cmd("down_zero", 0, 400);
        steps(2 * TD);
        chk("down_nowrap", 32'(MotorCommand), 0);

        // 3. brake at cmd=500
        ar_i = 500;
        wait_cmd("brk_pre", 500, 400);
        brk_i = 1;
        steps(3);
        chk("brk_cmd", 32'(MotorCommand), 0);
        chk("brk_state", 32'(State), BRK);
        steps(5);
        brk_i = 0;
        for (int i = 0; i < 20 && m_st != RUN; i++) step();
        chk("brk_rerun", 32'(State), RUN);
        for (int i = 0; i < 2 * TD && m_cmd == 0; i++) step();
        chk("brk_restart", 32'(MotorCommand), 8);

        // 4. tilt
        wait_cmd("tilt_pre", 500, 400);
        roll_i = -46;
        step();
        chk("tilt_cmd", 32'(MotorCommand), 0);
        chk("tilt_tf", 32'(TiltFault), 1);
        roll_i = 41;
        steps(10 * TD);
        chk("tilt_hold41", 32'(State), TILT);
        roll_i = 40;
        steps(4 * TD);
        chk("tilt_4ticks", 32'(State), TILT);
        steps(TD);
        chk("tilt_cleared", 32'(State != 2'd3), 1);
        steps(3 * TD);
        roll_i = -512;
        step();
        chk("tilt_abs512", 32'(TiltFault), 1);
        roll_i = 0;
        steps(8 * TD);
        chk("tilt_recover", 32'(TiltFault), 0);

        // 5. cadence loss, then edge coinciding with a tick
        ar_i = 200;
        wait_cmd("cad_pre", 200, 400);
        cad_period = 0; cad_force = 0;
        for (int i = 0; i < 15 * TD && m_ped != 0; i++) step();
        chk("cad_lost", 32'(Pedalling), 0);
        for (int i = 0; i < 20 * TD && m_st != IDLE; i++) step();
        chk("cad_idle", 32'(State), IDLE);
        chk("cad_cmd0", 32'(MotorCommand), 0);
        for (int i = 0; i < TD && m_phase != 1; i++) step();
        cad_force = 1;
        steps(3);
        chk("edge_tick_ped", 32'(Pedalling), 1);
        cad_force = 0;
        steps((CT - 1) * TD);
        chk("edge_tick_hold", 32'(Pedalling), 1);

        // 6. asynchronous reset mid-ramp
        cad_period = 3 * TD; ar_i = 300;
        wait_cmd("rst_pre", 300, 400);
        #2 reset = 1'b1; rst_i = 1;
        #1;
        chk("arst_cmd", 32'(MotorCommand), 0);
        chk("arst_en", 32'(MotorEnable), 0);
        chk("arst_state", 32'(State), IDLE);
        chk("arst_ped", 32'(Pedalling), 0);
        model_reset();
        steps(2);
        rst_i = 0;
        step();
        chk("arst_rel_ped", 32'(Pedalling), 0);
        chk("arst_rel_state", 32'(State), IDLE);

        // 7. randomized mix
        for (int s = 0; s < 250; s++) begin
            int r;
            ar_i = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 8191) : $urandom_range(0, 600);
            r = $urandom_range(0, 19);
            if (r == 0)      roll_i = $urandom_range(0, 1023) - 512;
            else if (r < 3)  roll_i = ($urandom_range(0, 1) ? 1 : -1) * $urandom_range(38, 50);
            else             roll_i = $urandom_range(0, 60) - 30;
            brk_i = ($urandom_range(0, 9) == 0);
            cad_period = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(6, 40);
            steps(8);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
